// File: rtl/clock_text_gen.sv
// Text renderer for the "HH:MM:SS AM/PM" clock line: maps VGA pixels to glyph cells,
// addresses the 8x16 digit ROM and emits registered 12-bit RGB two clocks after x/y.
module clock_text_gen #(
  parameter logic [9:0]  X0           = 10'd192,
  parameter logic [9:0]  Y0           = 10'd224,
  parameter int          SCALE_SHIFT  = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  hr_10,
  input  logic [3:0]  hr_1,
  input  logic [2:0]  min_10,
  input  logic [3:0]  min_1,
  input  logic [2:0]  sec_10,
  input  logic [3:0]  sec_1,
  input  logic        pm,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic [11:0] rgb
);

  localparam int          CW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] X_END      = 11'(X0) + 11'(88 << SCALE_SHIFT);
  localparam logic [10:0] Y_END      = 11'(Y0) + 11'(16 << SCALE_SHIFT);
  localparam logic [10:0] BLANK_ADDR = 11'h300;

  // Frame-start snapshot of the time so a frame never shows two different times.
  logic [1:0] hr_10_q;
  logic [3:0] hr_1_q;
  logic [2:0] min_10_q;
  logic [3:0] min_1_q;
  logic [2:0] sec_10_q;
  logic [3:0] sec_1_q;
  logic       pm_q;

  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          colon_vis_q, colon_vis_d;
  logic          frame_start;

  assign frame_start = p_tick & (x == 10'd0) & (y == 10'd0);

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    colon_vis_d = colon_vis_q;
    if (frame_start) begin
      if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        colon_vis_d = ~colon_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hr_10_q     <= '0;
      hr_1_q      <= '0;
      min_10_q    <= '0;
      min_1_q     <= '0;
      sec_10_q    <= '0;
      sec_1_q     <= '0;
      pm_q        <= 1'b0;
      blink_cnt_q <= '0;
      colon_vis_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      colon_vis_q <= colon_vis_d;
      if (frame_start) begin
        hr_10_q  <= hr_10;
        hr_1_q   <= hr_1;
        min_10_q <= min_10;
        min_1_q  <= min_1;
        sec_10_q <= sec_10;
        sec_1_q  <= sec_1;
        pm_q     <= pm;
      end
    end
  end

  // Stage 0: geometry. dx/dy wrap left of / above the line; in_region masks that.
  logic [9:0] dx, dy;
  logic [6:0] col;
  logic [3:0] char_idx;
  logic [2:0] bit_idx;
  logic [3:0] glyph_row;
  logic       in_region;

  assign dx        = x - X0;
  assign dy        = y - Y0;
  assign col       = 7'(dx >> SCALE_SHIFT);
  assign char_idx  = col[6:3];
  assign bit_idx   = col[2:0];
  assign glyph_row = 4'(dy >> SCALE_SHIFT);
  assign in_region = (x >= X0) && ({1'b0, x} < X_END) &&
                     (y >= Y0) && ({1'b0, y} < Y_END);

  logic [3:0] digit;
  logic       is_digit;
  logic [6:0] char_code;
  logic       blank;

  always_comb begin
    digit     = 4'd0;
    is_digit  = 1'b0;
    char_code = 7'h00;
    blank     = 1'b0;
    case (char_idx)
      4'd0:       begin digit = {2'b00, hr_10_q};  is_digit = 1'b1; end
      4'd1:       begin digit = hr_1_q;            is_digit = 1'b1; end
      4'd3:       begin digit = {1'b0, min_10_q};  is_digit = 1'b1; end
      4'd4:       begin digit = min_1_q;           is_digit = 1'b1; end
      4'd6:       begin digit = {1'b0, sec_10_q};  is_digit = 1'b1; end
      4'd7:       begin digit = sec_1_q;           is_digit = 1'b1; end
      4'd2, 4'd5: begin char_code = 7'h3a; blank = ~colon_vis_q; end
      4'd9:       char_code = pm_q ? 7'h41 : 7'h40;
      4'd10:      char_code = 7'h4d;
      default:    blank = 1'b1;
    endcase
    if (is_digit) begin
      char_code = 7'h30 + {3'b000, digit};
      if (digit > 4'd9) blank = 1'b1;
    end
  end

  logic lit_en_d;

  assign lit_en_d = in_region & ~blank;
  assign rom_addr = lit_en_d ? {char_code, glyph_row} : BLANK_ADDR;

  // Stage 1 lines up with the ROM's registered read; stage 2 forms the pixel.
  logic [2:0]  bit_idx_q;
  logic        lit_en_q;
  logic        video_on_q;
  logic        text_on_q;
  logic [11:0] rgb_q;
  logic        pix;

  assign pix = lit_en_q & rom_data[3'd7 - bit_idx_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx_q  <= '0;
      lit_en_q   <= 1'b0;
      video_on_q <= 1'b0;
      text_on_q  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      bit_idx_q  <= bit_idx;
      lit_en_q   <= lit_en_d;
      video_on_q <= video_on;
      text_on_q  <= pix & video_on_q;
      rgb_q      <= ~video_on_q ? 12'h000 : (pix ? FG_COLOR : BG_COLOR);
    end
  end

  assign text_on = text_on_q;
  assign rgb     = rgb_q;

endmodule

// File: tb/tb_clock_text_gen.sv
// Bench for clock_text_gen: constant vector table, hand sequences for blink/reset/pm,
// and randomized pixels checked against an arithmetic model of the text line.
module tb_clock_text_gen;

  localparam int X0 = 192;
  localparam int Y0 = 224;
  localparam int S  = 2;
  localparam int BLINK = 30;
  localparam logic [12:0] O_LIT = {1'b1, 12'hFFF};
  localparam logic [12:0] O_BG  = {1'b0, 12'h008};
  localparam logic [12:0] O_OFF = 13'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [1:0]  hr_10 = '0;
  logic [3:0]  hr_1 = '0;
  logic [2:0]  min_10 = '0;
  logic [3:0]  min_1 = '0;
  logic [2:0]  sec_10 = '0;
  logic [3:0]  sec_1 = '0;
  logic        pm = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [11:0] rgb;

  clock_text_gen #(
    .X0(10'd192), .Y0(10'd224), .SCALE_SHIFT(2), .BLINK_FRAMES(30),
    .FG_COLOR(12'hFFF), .BG_COLOR(12'h008)
  ) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .hr_10(hr_10), .hr_1(hr_1), .min_10(min_10), .min_1(min_1),
    .sec_10(sec_10), .sec_1(sec_1), .pm(pm), .rom_addr(rom_addr),
    .rom_data(rom_data), .text_on(text_on), .rgb(rgb)
  );

  // clock and ROM environment
  always #5 clk = ~clk;

  logic [7:0] rom_mem [2048];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [26:0] exp_q[$];

  // model state: snapshot of the time and frame count since reset
  int s_dig[6];
  bit s_pm;
  int frames;

  typedef struct {
    int          xi;
    int          yi;
    bit          vo;
    logic [10:0] addr;
    logic [12:0] out;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_code(input int ch);
    bit hidden;
    int d;
    hidden = ((frames / BLINK) % 2) == 1;
    d = -1;
    case (ch)
      0, 1: d = s_dig[ch];
      3, 4: d = s_dig[ch - 1];
      6, 7: d = s_dig[ch - 2];
      2, 5: return hidden ? -1 : 58;
      9:    return s_pm ? 65 : 64;
      10:   return 77;
      default: return -1;
    endcase
    return (d > 9) ? -1 : 48 + d;
  endfunction

  task automatic ref_pix(input int xi, input int yi, output logic [10:0] a, output bit le,
                         output int bn);
    int sc, col, row, code;
    sc = 1 << S;
    a = 11'h300;
    le = 1'b0;
    bn = 0;
    if (xi >= X0 && xi < X0 + 88 * sc && yi >= Y0 && yi < Y0 + 16 * sc) begin
      col = (xi - X0) / sc;
      bn = col % 8;
      row = ((yi - Y0) / sc) % 16;
      code = ref_code(col / 8);
      if (code >= 0) begin
        le = 1'b1;
        a = 11'(code * 16 + row);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) s_dig[i] = 0;
    s_pm = 1'b0;
    frames = 0;
  endtask

  task automatic set_time(input int h10, h1, m10, m1, s10, s1, input bit p);
    hr_10 = 2'(h10); hr_1 = 4'(h1); min_10 = 3'(m10); min_1 = 4'(m1);
    sec_10 = 3'(s10); sec_1 = 4'(s1); pm = p;
  endtask

  // One pixel clock: drive, check address, queue pixel expectation, check output of 2 clk ago.
  task automatic step(input int xi, input int yi, input bit vo, input bit pt,
                      input bit ca, input logic [10:0] taddr,
                      input bit co, input logic [12:0] tout, input string tag);
    logic [10:0] ma;
    bit le;
    int bn;
    logic [7:0] row_bits;
    logic [12:0] mo;
    logic [26:0] e;
    bit lit;
    x = 10'(xi); y = 10'(yi); video_on = vo; p_tick = pt;
    #1;
    ref_pix(xi, yi, ma, le, bn);
    row_bits = rom_mem[ma];
    lit = le && row_bits[7 - bn];
    mo = !vo ? O_OFF : (lit ? O_LIT : O_BG);
    check({tag, "_addr"}, 32'(rom_addr), 32'(ma));
    if (ca) check({tag, "_addr_const"}, 32'(rom_addr), 32'(taddr));
    exp_q.push_back({co, tout, mo});
    @(posedge clk);
    if (pt && xi == 0 && yi == 0) begin
      s_dig[0] = int'(hr_10); s_dig[1] = int'(hr_1); s_dig[2] = int'(min_10);
      s_dig[3] = int'(min_1); s_dig[4] = int'(sec_10); s_dig[5] = int'(sec_1);
      s_pm = pm;
      frames++;
    end
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check({tag, "_pix"}, 32'({text_on, rgb}), 32'(e[12:0]));
      if (e[26]) check({tag, "_pix_const"}, 32'({text_on, rgb}), 32'(e[25:13]));
    end
  endtask

  task automatic frame_start();
    step(0, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "fstart");
  endtask

  task automatic flush();
    step(1023, 1023, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, "flush");
    step(1023, 1023, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, "flush");
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_rgb"}, 32'(rgb), 32'h0);
    check({tag, "_text_on"}, 32'(text_on), 32'h0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vecs = '{
      '{192, 232, 1'b1, 11'h312, O_BG},
      '{204, 232, 1'b1, 11'h312, O_LIT},
      '{208, 232, 1'b1, 11'h312, O_LIT},
      '{212, 232, 1'b1, 11'h312, O_BG},
      '{480, 232, 1'b1, 11'h412, O_LIT},
      '{496, 232, 1'b1, 11'h412, O_BG},
      '{191, 232, 1'b1, 11'h300, O_BG},
      '{543, 232, 1'b1, 11'h4d2, O_LIT},
      '{544, 232, 1'b1, 11'h300, O_BG},
      '{448, 232, 1'b1, 11'h300, O_BG},
      '{204, 232, 1'b0, 11'h312, O_OFF},
      '{204, 223, 1'b1, 11'h300, O_BG},
      '{204, 288, 1'b1, 11'h300, O_BG},
      '{204, 287, 1'b1, 11'h31f, O_LIT},
      '{1023, 232, 1'b1, 11'h300, O_BG},
      '{268, 232, 1'b1, 11'h3a2, O_BG},
      '{268, 240, 1'b1, 11'h3a4, O_LIT}
    };
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    for (int r = 0; r < 16; r++) rom_mem[11'h3a0 + r] = 8'h00;
    rom_mem[11'h312] = 8'b0001_1000;
    rom_mem[11'h31f] = 8'h10;
    rom_mem[11'h412] = 8'b1111_0000;
    rom_mem[11'h402] = 8'h80;
    rom_mem[11'h4d2] = 8'h01;
    rom_mem[11'h300] = 8'hFF;
    rom_mem[11'h3a4] = 8'b0001_1000;
    rom_mem[11'h3a5] = 8'b0001_1000;
    rom_mem[11'h3a8] = 8'b0001_1000;
    rom_mem[11'h3a9] = 8'b0001_1000;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("init_rgb", 32'(rgb), 32'h0);
    check("init_text_on", 32'(text_on), 32'h0);
    reset_n = 1'b1;

    // vector table at glyph row 2, time 12:34:56 PM
    set_time(1, 2, 3, 4, 5, 6, 1'b1);
    frame_start();
    for (int i = 0; i < 17; i++)
      step(vecs[i].xi, vecs[i].yi, vecs[i].vo, 1'b0, 1'b1, vecs[i].addr, 1'b1, vecs[i].out,
           $sformatf("vec%0d", i));

    // pm change mid-frame only takes effect at the next frame start
    pm = 1'b0;
    step(480, 232, 1'b1, 1'b0, 1'b1, 11'h412, 1'b1, O_LIT, "pm_hold");
    frame_start();
    step(480, 232, 1'b1, 1'b0, 1'b1, 11'h402, 1'b1, O_LIT, "pm_am");
    flush();

    // invalid BCD in sec_1 blanks char 7; char 8 is always blank
    sec_1 = 4'hC;
    frame_start();
    for (int r = 0; r < 64; r++)
      for (int b = 0; b < 8; b++) begin
        step(X0 + 7 * 32 + b * 4, Y0 + r, 1'b1, 1'b0, 1'b1, 11'h300, 1'b1, O_BG, "bad_bcd");
        step(X0 + 8 * 32 + b * 4, Y0 + r, 1'b1, 1'b0, 1'b1, 11'h300, 1'b1, O_BG, "space");
      end
    flush();

    // reset while a lit pixel is on the output
    set_time(1, 2, 3, 4, 5, 6, 1'b1);
    frame_start();
    repeat (3) step(204, 232, 1'b1, 1'b0, 1'b1, 11'h312, 1'b1, O_LIT, "pre_rst");
    do_reset("mid_rst");

    // blink: after reset the line reads 00:00:00 AM; colons hidden for frames 30-59
    for (int f = 0; f <= 60; f++) begin
      bit vis;
      vis = (f < 30) || (f >= 60);
      if (f == 0) begin
        step(192, 232, 1'b1, 1'b0, 1'b1, 11'h302, 1'b0, '0, "zero_h10");
        step(480, 232, 1'b1, 1'b0, 1'b1, 11'h402, 1'b1, O_LIT, "zero_am");
      end
      step(268, 240, 1'b1, 1'b0, 1'b1, vis ? 11'h3a4 : 11'h300, 1'b1, vis ? O_LIT : O_BG,
           $sformatf("colon2_f%0d", f));
      step(364, 256, 1'b1, 1'b0, 1'b1, vis ? 11'h3a8 : 11'h300, 1'b1, vis ? O_LIT : O_BG,
           $sformatf("colon5_f%0d", f));
      frame_start();
    end

    // randomized pixels and time changes against the model
    for (int n = 0; n < 3000; n++) begin
      int xi, yi;
      if ($urandom_range(0, 49) == 0)
        set_time($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) begin
        frame_start();
      end else begin
        if ($urandom_range(0, 9) == 0) begin
          xi = $urandom_range(0, 1023);
          yi = $urandom_range(0, 1023);
        end else begin
          xi = $urandom_range(X0 - 8, X0 + 88 * 4 + 8);
          yi = $urandom_range(Y0 - 4, Y0 + 64 + 4);
        end
        step(xi, yi, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, '0,
             "rand");
      end
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
